axis_pattern_source: RTL and testbench

//   AXI-Stream transmitter that feeds the DMA S2MM (stream-to-memory) channel. It is the

---
 rtl/axis_pattern_source_if.sv | 20 ++
 rtl/axis_pattern_source.sv | 157 +++++++++++++++
 tb/tb_axis_pattern_source.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axis_pattern_source_if.sv
// AXI-Stream bus between the pattern source and the DMA S2MM channel.
interface axis_pattern_source_if #(
  parameter int DATA_W = 64
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_W-1:0]     tdata;
  logic                  tlast;
  logic [DATA_W/8-1:0]   tkeep;

  modport master (
    output tvalid, tdata, tlast, tkeep,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tlast, tkeep,
    output tready
  );
endinterface

// File: rtl/axis_pattern_source.sv
// AXI-Stream packet generator (INCR / CONST / LFSR patterns) feeding the DMA S2MM channel.
// Emits gen_length beats per start pulse, TLAST on the final beat, full TREADY backpressure.
module axis_pattern_source #(
  parameter int DATA_W = 64,
  parameter int LEN_W  = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               gen_en,
  input  logic               gen_start,
  input  logic [LEN_W-1:0]   gen_length,
  input  logic [DATA_W-1:0]  gen_seed,
  input  logic [DATA_W-1:0]  gen_step,
  input  logic [1:0]         gen_mode,
  output logic               gen_busy,
  output logic               gen_done,
  output logic [LEN_W-1:0]   gen_count,
  axis_pattern_source_if.master m_axis
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam logic [DATA_W-1:0] LFSR_TAPS = 64'hD800_0000_0000_0000;

  state_e              state_q, state_d;
  mode_e               mode_q;
  logic [LEN_W-1:0]    len_q;
  logic [DATA_W-1:0]   seed_q;
  logic [DATA_W-1:0]   step_q;
  logic [DATA_W-1:0]   tdata_q;
  logic                tvalid_q;
  logic                tlast_q;
  logic [LEN_W-1:0]    count_q;
  logic                done_q;

  logic                fire;
  logic                start_run;
  logic                start_zero;
  logic [DATA_W-1:0]   seed_eff;
  logic [DATA_W-1:0]   lfsr_next;
  logic [DATA_W-1:0]   pat_next;

  // Starts are honoured from IDLE and DONE only; a start during RUN is dropped.
  assign start_run  = (state_q != RUN) && gen_en && gen_start && (gen_length != '0);
  assign start_zero = (state_q != RUN) && gen_en && gen_start && (gen_length == '0);
  assign fire       = (state_q == RUN) && tvalid_q && m_axis.tready;

  // An all-zero LFSR state would lock up, so a zero seed is promoted to 1.
  assign seed_eff = ((mode_e'(gen_mode) == MODE_LFSR) && (gen_seed == '0)) ? DATA_W'(1) : gen_seed;

  always_comb begin
    lfsr_next = {1'b0, tdata_q[DATA_W-1:1]} ^ (tdata_q[0] ? LFSR_TAPS : '0);
    unique case (mode_q)
      MODE_CONST: pat_next = seed_q;
      MODE_LFSR:  pat_next = lfsr_next;
      default:    pat_next = tdata_q + step_q;
    endcase
  end

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (gen_en && gen_start)
          state_d = (gen_length != '0) ? RUN : DONE;
        else if (!gen_en)
          state_d = IDLE;
      end
      RUN: begin
        if (fire && tlast_q)
          state_d = DONE;
        else if (!gen_en && (fire || !tvalid_q))
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    gen_busy      = (state_q == RUN);
    gen_done      = done_q;
    gen_count     = count_q;
    m_axis.tvalid = tvalid_q;
    m_axis.tdata  = tdata_q;
    m_axis.tlast  = tlast_q;
    m_axis.tkeep  = '1;
  end

  // Beat datapath: stream registers only move on a start or a completed transfer,
  // which keeps tdata/tlast/tvalid stable under backpressure.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q   <= MODE_INCR;
      len_q    <= '0;
      seed_q   <= '0;
      step_q   <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      count_q  <= '0;
    end else if (start_run) begin
      mode_q   <= mode_e'(gen_mode);
      len_q    <= gen_length;
      seed_q   <= seed_eff;
      step_q   <= gen_step;
      tdata_q  <= seed_eff;
      tvalid_q <= 1'b1;
      tlast_q  <= (gen_length == LEN_W'(1));
      count_q  <= '0;
    end else if (start_zero) begin
      len_q    <= '0;
      count_q  <= '0;
    end else if (fire) begin
      if (count_q != len_q)
        count_q <= count_q + LEN_W'(1);
      if (tlast_q || !gen_en) begin
        tvalid_q <= 1'b0;
        tlast_q  <= 1'b0;
      end else begin
        tdata_q  <= pat_next;
        tlast_q  <= ((count_q + LEN_W'(2)) == len_q);
      end
    end
  end

  // Sticky completion flag; an abort never sets it.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)
      done_q <= 1'b0;
    else if (start_run)
      done_q <= 1'b0;
    else if (start_zero || (fire && tlast_q))
      done_q <= 1'b1;
    else if (!gen_en)
      done_q <= 1'b0;
  end

endmodule

// File: tb/tb_axis_pattern_source.sv
// Directed self-checking bench for axis_pattern_source.
module tb_axis_pattern_source;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        gen_en = 1'b0;
  logic        gen_start = 1'b0;
  logic [31:0] gen_length = '0;
  logic [63:0] gen_seed = '0;
  logic [63:0] gen_step = '0;
  logic [1:0]  gen_mode = '0;
  logic        gen_busy;
  logic        gen_done;
  logic [31:0] gen_count;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_d [0:7];

  always #5 sys_clk = ~sys_clk;

  axis_pattern_source_if #(.DATA_W(64)) axis ();

  axis_pattern_source #(.DATA_W(64), .LEN_W(32)) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .gen_en     (gen_en),
    .gen_start  (gen_start),
    .gen_length (gen_length),
    .gen_seed   (gen_seed),
    .gen_step   (gen_step),
    .gen_mode   (gen_mode),
    .gen_busy   (gen_busy),
    .gen_done   (gen_done),
    .gen_count  (gen_count),
    .m_axis     (axis)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start_pkt(input logic [1:0] mode, input logic [63:0] seed,
                           input logic [63:0] step, input logic [31:0] len);
    gen_en     = 1'b1;
    gen_mode   = mode;
    gen_seed   = seed;
    gen_step   = step;
    gen_length = len;
    gen_start  = 1'b1;
    tick();
    gen_start  = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    gen_en = 1'b0;
    tick();
    chk({tag, "_idle_done"}, 64'(gen_done), 64'd0);
    chk({tag, "_idle_busy"}, 64'(gen_busy), 64'd0);
    gen_en = 1'b1;
  endtask

  // Checks n beats against exp_d with tready held high, then the completion cycle.
  task automatic run_packet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), 64'(axis.tvalid), 64'd1);
      chk($sformatf("%s_data%0d", tag, i), axis.tdata, exp_d[i]);
      chk($sformatf("%s_last%0d", tag, i), 64'(axis.tlast), 64'(i == n - 1));
      tick();
    end
    chk({tag, "_end_valid"}, 64'(axis.tvalid), 64'd0);
    chk({tag, "_end_done"}, 64'(gen_done), 64'd1);
    chk({tag, "_end_busy"}, 64'(gen_busy), 64'd0);
    chk({tag, "_end_count"}, 64'(gen_count), 64'(n));
  endtask

  initial begin
    axis.tready = 1'b0;
    #12;
    chk("rst_valid", 64'(axis.tvalid), 64'd0);
    chk("rst_data",  axis.tdata, 64'd0);
    chk("rst_last",  64'(axis.tlast), 64'd0);
    chk("rst_keep",  64'(axis.tkeep), 64'hFF);
    chk("rst_busy",  64'(gen_busy), 64'd0);
    chk("rst_done",  64'(gen_done), 64'd0);
    chk("rst_count", 64'(gen_count), 64'd0);
    sys_rst_n = 1'b1;
    tick();

    // INCR, tready high
    axis.tready = 1'b1;
    start_pkt(2'd0, 64'h10, 64'd2, 32'd4);
    chk("t1_busy", 64'(gen_busy), 64'd1);
    exp_d[0] = 64'h10; exp_d[1] = 64'h12; exp_d[2] = 64'h14; exp_d[3] = 64'h16;
    run_packet("t1", 4);

    // Same packet with tready pattern 1,0,0,1,0,0,...
    go_idle("t2");
    start_pkt(2'd0, 64'h10, 64'd2, 32'd4);
    begin
      int idx = 0;
      for (int c = 0; c < 30 && idx < 4; c++) begin
        chk($sformatf("t2_valid_c%0d", c), 64'(axis.tvalid), 64'd1);
        chk($sformatf("t2_data_c%0d", c), axis.tdata, exp_d[idx]);
        chk($sformatf("t2_last_c%0d", c), 64'(axis.tlast), 64'(idx == 3));
        axis.tready = ((c % 3) == 0);
        tick();
        if (axis.tready) idx++;
      end
      chk("t2_beats", 64'(idx), 64'd4);
    end
    axis.tready = 1'b1;
    chk("t2_end_valid", 64'(axis.tvalid), 64'd0);
    chk("t2_end_done",  64'(gen_done), 64'd1);
    chk("t2_end_count", 64'(gen_count), 64'd4);

    // INCR wrap at 2^64
    go_idle("t3");
    start_pkt(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'd3);
    exp_d[0] = 64'hFFFF_FFFF_FFFF_FFFF; exp_d[1] = 64'h0; exp_d[2] = 64'h1;
    run_packet("t3", 3);

    // LFSR with zero seed
    go_idle("t4");
    start_pkt(2'd2, 64'h0, 64'd0, 32'd3);
    exp_d[0] = 64'h1; exp_d[1] = 64'hD800_0000_0000_0000; exp_d[2] = 64'h6C00_0000_0000_0000;
    run_packet("t4", 3);

    // CONST
    go_idle("t4c");
    start_pkt(2'd1, 64'hA5A5, 64'd9, 32'd2);
    exp_d[0] = 64'hA5A5; exp_d[1] = 64'hA5A5;
    run_packet("t4c", 2);

    // Abort on beat 2 of 8 while stalled
    go_idle("t5");
    start_pkt(2'd0, 64'h0, 64'd1, 32'd8);
    chk("t5_b1_data", axis.tdata, 64'd0);
    tick();
    chk("t5_b2_data", axis.tdata, 64'd1);
    axis.tready = 1'b0;
    gen_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("t5_hold_valid%0d", i), 64'(axis.tvalid), 64'd1);
      chk($sformatf("t5_hold_data%0d", i), axis.tdata, 64'd1);
      chk($sformatf("t5_hold_last%0d", i), 64'(axis.tlast), 64'd0);
    end
    axis.tready = 1'b1;
    tick();
    chk("t5_valid", 64'(axis.tvalid), 64'd0);
    chk("t5_last",  64'(axis.tlast), 64'd0);
    chk("t5_done",  64'(gen_done), 64'd0);
    chk("t5_busy",  64'(gen_busy), 64'd0);
    chk("t5_count", 64'(gen_count), 64'd2);
    gen_en = 1'b1;

    // Zero length, ignored restarts, async reset mid-packet
    start_pkt(2'd0, 64'h55, 64'd1, 32'd0);
    chk("t6_zl_done",  64'(gen_done), 64'd1);
    chk("t6_zl_valid", 64'(axis.tvalid), 64'd0);
    chk("t6_zl_count", 64'(gen_count), 64'd0);
    go_idle("t6");
    start_pkt(2'd0, 64'd100, 64'd1, 32'd5);
    chk("t6_r_data0", axis.tdata, 64'd100);
    gen_seed = 64'd7; gen_length = 32'd2; gen_start = 1'b1;
    tick();
    chk("t6_r_data1", axis.tdata, 64'd101);
    chk("t6_r_busy1", 64'(gen_busy), 64'd1);
    tick();
    gen_start = 1'b0;
    chk("t6_r_data2", axis.tdata, 64'd102);
    chk("t6_r_count", 64'(gen_count), 64'd2);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(axis.tvalid), 64'd0);
    chk("t6_rst_data",  axis.tdata, 64'd0);
    chk("t6_rst_busy",  64'(gen_busy), 64'd0);
    chk("t6_rst_count", 64'(gen_count), 64'd0);
    chk("t6_rst_keep",  64'(axis.tkeep), 64'hFF);
    tick();
    sys_rst_n = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
